// File: rtl/ro_frame_pkg.sv
// Shared types and helpers for the ring-oscillator frame serializer.
// The CRC-8 trailer is built only when RO_FRAME_CRC8_EN is defined.
package ro_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CRC     = 3'd3,
    ST_GAP     = 3'd4
  } frame_state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam int         CRC8_LEN  = 8;

  // Longest segment the shared bit counter must span (CRC trailer included).
  function automatic int seg_max(input int sync_len, input int pay_len, input int gap_len);
    int m;
    m = CRC8_LEN;
    if (sync_len > m) m = sync_len;
    if (pay_len > m) m = pay_len;
    if (gap_len > m) m = gap_len;
    return m;
  endfunction

  // One spare bit so the terminal count never aliases to zero.
  function automatic int cnt_width(input int max_len);
    return $clog2(max_len) + 32'sd1;
  endfunction

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    return {crc[6:0], 1'b0} ^ (((crc[7] ^ din) == 1'b1) ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/ro_frame_serializer_crc.sv
// Bit-serial CRC-8 (MSB-first shift, init 0x00, no reflection, no final xor).
// Only instantiated when RO_FRAME_CRC8_EN is defined.
module ro_crc8_serial
  import ro_frame_pkg::*;
(
  input  logic       data_clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;

  // Clear wins over a data step so a new frame always starts from zero.
  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = 8'h00;
    end else if (en) begin
      crc_d = crc8_step(crc_q, din);
    end else begin
      crc_d = crc_q;
    end
  end

  // CRC register.
  always_ff @(posedge data_clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/ro_frame_serializer.sv
// Snapshots N_CH count words and shifts them out behind a sync header, stepping sel per frame.
// Defining RO_FRAME_CRC8_EN appends a CRC-8 trailer over the payload bits.
module ro_frame_serializer
  import ro_frame_pkg::*;
#(
  parameter int                N_CH      = 8,
  parameter int                CNT_W     = 32,
  parameter int                SEL_W     = 2,
  parameter int                SYNC_W    = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD = 8'hA5,
  parameter int                GAP_CYC   = 4
) (
  input  logic                  data_clk,
  input  logic                  reset_n,
  input  logic [N_CH*CNT_W-1:0] counts_flat,
  input  logic                  start,
  input  logic                  free_run,
  output logic [SEL_W-1:0]      sel,
  output logic                  data_out,
  output logic                  bit_valid,
  output logic                  frame_sync,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int PAY_LEN = N_CH * CNT_W;
  localparam int CW      = cnt_width(seg_max(SYNC_W, PAY_LEN, GAP_CYC));

  localparam logic [CW-1:0] HDR_LAST = CW'(SYNC_W - 1);
  localparam logic [CW-1:0] PAY_LAST = CW'(PAY_LEN - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);

  frame_state_e         state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PAY_LEN-1:0]   snap_q, snap_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 sync_q, sync_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 frame_start_s;
  logic                 frame_end_s;

`ifdef RO_FRAME_CRC8_EN
  localparam logic [CW-1:0] CRC_LAST = CW'(CRC8_LEN - 1);

  logic [7:0] crc_s;
  logic       crc_clr_s;
  logic       crc_en_s;

  ro_crc8_serial u_crc (
    .data_clk (data_clk),
    .reset_n  (reset_n),
    .clr      (crc_clr_s),
    .en       (crc_en_s),
    .din      (data_d),
    .crc      (crc_s)
  );
`endif

  // Next state: state_q/cnt_q always describe the bit currently on data_out.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + CW'(1);
    snap_d        = snap_q;
    sel_d         = sel_q;
    frame_start_s = 1'b0;
    frame_end_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start | free_run) frame_start_s = 1'b1;
        else                  frame_start_s = 1'b0;
      end
      ST_HEADER: begin
        if (cnt_q == HDR_LAST) begin
          state_d = ST_PAYLOAD;
          cnt_d   = '0;
        end else begin
          state_d = ST_HEADER;
        end
      end
      ST_PAYLOAD: begin
        if (cnt_q == PAY_LAST) begin
`ifdef RO_FRAME_CRC8_EN
          state_d = ST_CRC;
          cnt_d   = '0;
`else
          frame_end_s = 1'b1;
`endif
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
`ifdef RO_FRAME_CRC8_EN
      ST_CRC: begin
        if (cnt_q == CRC_LAST) frame_end_s = 1'b1;
        else                   state_d = ST_CRC;
      end
`endif
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (free_run) frame_start_s = 1'b1;
          else          state_d = ST_IDLE;
        end else begin
          state_d = ST_GAP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (frame_end_s) begin
      sel_d = sel_q + SEL_W'(1);
      cnt_d = '0;
      if (GAP_CYC > 0)   state_d = ST_GAP;
      else if (free_run) frame_start_s = 1'b1;
      else               state_d = ST_IDLE;
    end else begin
      sel_d = sel_q;
    end

    if (frame_start_s) begin
      state_d = ST_HEADER;
      cnt_d   = '0;
      snap_d  = counts_flat;
    end else begin
      snap_d = snap_q;
    end
  end

  // Output bits are chosen from the next state so they land registered with it.
  always_comb begin
    data_d  = 1'b0;
    valid_d = 1'b0;
    sync_d  = 1'b0;
    done_d  = 1'b0;
    busy_d  = (state_d != ST_IDLE);
`ifdef RO_FRAME_CRC8_EN
    crc_clr_s = frame_start_s;
    crc_en_s  = 1'b0;
`endif
    case (state_d)
      ST_HEADER: begin
        data_d  = |(SYNC_WORD & (SYNC_W'(1'b1) << (HDR_LAST - cnt_d)));
        valid_d = 1'b1;
        sync_d  = 1'b1;
      end
      ST_PAYLOAD: begin
        data_d  = |(snap_d & (PAY_LEN'(1'b1) << cnt_d));
        valid_d = 1'b1;
`ifdef RO_FRAME_CRC8_EN
        crc_en_s = 1'b1;
`else
        done_d = (cnt_d == PAY_LAST);
`endif
      end
`ifdef RO_FRAME_CRC8_EN
      ST_CRC: begin
        data_d  = |(crc_s & (8'h80 >> cnt_d));
        valid_d = 1'b1;
        done_d  = (cnt_d == CRC_LAST);
      end
`endif
      default: begin
        data_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge data_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      snap_q  <= '0;
      sel_q   <= '0;
      data_q  <= 1'b0;
      valid_q <= 1'b0;
      sync_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sync_q  <= sync_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sel        = sel_q;
  assign data_out   = data_q;
  assign bit_valid  = valid_q;
  assign frame_sync = sync_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_ro_frame_serializer.sv
// Randomised bench for ro_frame_serializer: a frame-queue model predicts every output cycle.
// Honours RO_FRAME_CRC8_EN for frame length and the CRC trailer.
module tb_ro_frame_serializer;

  localparam int N_CH   = 8;
  localparam int CNT_W  = 32;
  localparam int PAY    = N_CH * CNT_W;
  localparam int SYNC_W = 8;
  localparam int GAP    = 4;
  localparam logic [7:0] SYNC_TB = 8'hA5;
`ifdef RO_FRAME_CRC8_EN
  localparam int CRC_LEN = 8;
`else
  localparam int CRC_LEN = 0;
`endif
  localparam int FRAME_LEN = SYNC_W + PAY + CRC_LEN;

  logic           data_clk;
  logic           reset_n;
  logic [PAY-1:0] counts_flat;
  logic           start, free_run;
  logic [1:0]     sel;
  logic           data_out, bit_valid, frame_sync, busy, frame_done;

  logic           start_s;
  logic [7:0]     counts_s;
  logic [1:0]     sel_s;
  logic           data_out_s, bit_valid_s, frame_sync_s, busy_s, frame_done_s;

  ro_frame_serializer dut (
    .data_clk(data_clk), .reset_n(reset_n), .counts_flat(counts_flat),
    .start(start), .free_run(free_run), .sel(sel), .data_out(data_out),
    .bit_valid(bit_valid), .frame_sync(frame_sync), .busy(busy), .frame_done(frame_done)
  );

  ro_frame_serializer #(.N_CH(1), .CNT_W(8)) dut_s (
    .data_clk(data_clk), .reset_n(reset_n), .counts_flat(counts_s),
    .start(start_s), .free_run(1'b0), .sel(sel_s), .data_out(data_out_s),
    .bit_valid(bit_valid_s), .frame_sync(frame_sync_s), .busy(busy_s), .frame_done(frame_done_s)
  );

  initial begin
    data_clk = 1'b0;
    forever #5 data_clk = ~data_clk;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // CRC-8 by long division of the 8-zero-augmented message by x^8+x^2+x+1.
  function automatic logic [7:0] crc_ref(input logic [PAY-1:0] c, input int n);
    logic [8:0] rem;
    rem = 9'd0;
    for (int i = 0; i < n + 8; i++) begin
      rem = {rem[7:0], (i < n) ? c[i] : 1'b0};
      if (rem[8]) rem = rem ^ 9'h107;
    end
    return rem[7:0];
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic       d;
    logic       v;
    logic       s;
    logic       dn;
    logic       b;
    logic [1:0] sel;
  } exp_t;

  exp_t       mq[$];
  exp_t       exp_cur = '0;
  logic [1:0] m_sel = 2'd0;
  bit         m_after = 1'b0;

  task automatic push_bit(input logic d, input logic s, input logic dn);
    exp_t e;
    e.d = d; e.v = 1'b1; e.s = s; e.dn = dn; e.b = 1'b1; e.sel = m_sel;
    mq.push_back(e);
  endtask

  task automatic build_frame(input logic [PAY-1:0] c);
    logic [7:0] crc;
    exp_t       e;
    for (int j = 0; j < SYNC_W; j++) push_bit(SYNC_TB[SYNC_W-1-j], 1'b1, 1'b0);
    for (int i = 0; i < PAY; i++) push_bit(c[i], 1'b0, (CRC_LEN == 0) && (i == PAY - 1));
    crc = crc_ref(c, PAY);
    for (int j = 0; j < CRC_LEN; j++) push_bit(crc[7-j], 1'b0, j == CRC_LEN - 1);
    m_sel = m_sel + 2'd1;
    for (int g = 0; g < GAP; g++) begin
      e = '0; e.b = 1'b1; e.sel = m_sel;
      mq.push_back(e);
    end
  endtask

  initial begin
    forever begin
      @(posedge data_clk or negedge reset_n);
      if (!reset_n) begin
        mq.delete(); m_sel = 2'd0; m_after = 1'b0; exp_cur = '0;
      end else begin
        if (mq.size() == 0) begin
          if (free_run || (start && !m_after)) build_frame(counts_flat);
          m_after = 1'b0;
        end
        if (mq.size() > 0) begin
          exp_cur = mq.pop_front();
          m_after = (mq.size() == 0);
        end else begin
          exp_cur = '0; exp_cur.sel = m_sel;
        end
      end
    end
  end

  // Cycle compare of every main-instance output against the model.
  initial begin
    logic [6:0] act;
    forever begin
      @(negedge data_clk);
      act = {data_out, bit_valid, frame_sync, frame_done, busy, sel};
      checks++;
      if (act !== exp_cur) begin
        failures++;
        $display("FAIL cycle_cmp t=%0t d/v/s/dn/b/sel got %b required %b", $time, act, exp_cur);
      end
    end
  end

  // ---------------- directed capture helpers ----------------
  logic       cap_d   [1:400];
  logic [1:0] cap_sel [1:400];

  task automatic rand_counts(output logic [PAY-1:0] c);
    for (int i = 0; i < N_CH; i++) c[i*CNT_W +: CNT_W] = $urandom;
  endtask

  task automatic run_frame(input int change_at, input logic [PAY-1:0] newc,
                           input int restart_at, input int reset_at, output int done_k);
    done_k = 0;
    start = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge data_clk);
      if (k == 1) start = 1'b0;
      cap_d[k] = data_out;
      cap_sel[k] = sel;
      if (k == change_at) counts_flat = newc;
      if (k == restart_at) start = 1'b1;
      if (k == restart_at + 1) start = 1'b0;
      if (k == reset_at) begin
        #2 reset_n = 1'b0;
        #1 chk("t4_rst_outputs", {data_out, bit_valid, frame_sync, frame_done, busy, sel}, 64'd0);
        done_k = -1;
        break;
      end
      if (frame_done) begin
        done_k = k;
        break;
      end
    end
    if (done_k == 0) chk("frame_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_frame(input string nm, input logic [PAY-1:0] c);
    logic [7:0]  hdr;
    logic [31:0] w;
    for (int j = 0; j < SYNC_W; j++) hdr[7-j] = cap_d[1+j];
    chk({nm, "_header"}, hdr, 8'b10100101);
    for (int i = 0; i < N_CH; i++) begin
      for (int b = 0; b < CNT_W; b++) w[b] = cap_d[SYNC_W + 1 + i*CNT_W + b];
      chk({nm, "_channel"}, w, c[i*CNT_W +: CNT_W]);
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge data_clk);
      n++;
      if (!busy) break;
    end
    chk("wait_idle_busy", busy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [PAY-1:0] c1, c2;
    logic [7:0]     sb;
    int dk, n, frames, idle_run, vcnt;
    logic prev_sync;
    logic [1:0] sels [5];
    int exp_sel [5] = '{1, 2, 3, 0, 1};

    reset_n = 1'b0; start = 1'b0; free_run = 1'b0; start_s = 1'b0;
    counts_flat = '0; counts_s = 8'h31;
    repeat (3) @(negedge data_clk);
    chk("rst_outputs", {data_out, bit_valid, frame_sync, frame_done, busy, sel}, 64'd0);
    reset_n = 1'b1;
    @(negedge data_clk);

    // T1: fixed counts, single start
    for (int i = 0; i < N_CH; i++) c1[i*CNT_W +: CNT_W] = 32'h1000_0000 + i;
    counts_flat = c1;
    run_frame(0, c1, 0, 0, dk);
    chk("t1_done_cycle", dk, FRAME_LEN);
    check_frame("t1", c1);
    chk("t1_sel_during", cap_sel[1], 2'd0);
    wait_idle(n);
    chk("t1_idle_latency", n, GAP + 1);
    chk("t1_sel_after", sel, 2'd1);

    // T2: free-run, five frames, counts changing underneath
    free_run = 1'b1; frames = 0; idle_run = 0; prev_sync = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge data_clk);
      if (frame_sync && !prev_sync) begin
        if (frames < 5) sels[frames] = sel;
        if (frames > 0) chk("t2_gap_cycles", idle_run, GAP);
        frames++;
        if (frames == 5) free_run = 1'b0;
      end
      prev_sync = frame_sync;
      if (bit_valid) idle_run = 0;
      else idle_run++;
      if ($urandom_range(1, 0) == 1) begin
        rand_counts(c2);
        counts_flat = c2;
      end
      if (frames >= 5 && !busy) break;
    end
    chk("t2_frames", frames, 5);
    chk("t2_end_idle", busy, 1'b0);
    for (int f = 0; f < 5; f++) chk("t2_sel_seq", sels[f], exp_sel[f]);

    // T3: counts change mid-payload
    rand_counts(c1); rand_counts(c2);
    counts_flat = c1;
    run_frame(SYNC_W + 50, c2, 0, 0, dk);
    chk("t3_done_cycle", dk, FRAME_LEN);
    check_frame("t3_first", c1);
    wait_idle(n);
    run_frame(0, c2, 0, 0, dk);
    check_frame("t3_second", c2);
    wait_idle(n);

    // T4: reset at payload bit 100
    rand_counts(c1);
    counts_flat = c1;
    run_frame(0, c1, 0, SYNC_W + 101, dk);
    chk("t4_aborted", dk, -1);
    repeat (2) @(negedge data_clk);
    #2 reset_n = 1'b1;
    @(negedge data_clk);
    chk("t4_busy_after", busy, 1'b0);
    chk("t4_sel_after", sel, 2'd0);
    rand_counts(c1);
    counts_flat = c1;
    run_frame(0, c1, 0, 0, dk);
    chk("t4_done_cycle", dk, FRAME_LEN);
    check_frame("t4", c1);
    chk("t4_sel_during", cap_sel[1], 2'd0);
    wait_idle(n);

    // T5: second start while busy
    rand_counts(c1);
    counts_flat = c1;
    run_frame(0, c1, 50, 0, dk);
    chk("t5_done_cycle", dk, FRAME_LEN);
    check_frame("t5", c1);
    wait_idle(n);
    chk("t5_idle_latency", n, GAP + 1);
    vcnt = 0;
    repeat (20) begin
      @(negedge data_clk);
      if (bit_valid) vcnt++;
    end
    chk("t5_no_extra_frame", vcnt, 0);

    // T6: small instance, payload 8'h31
    start_s = 1'b1;
    dk = 0; vcnt = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge data_clk);
      if (k == 1) start_s = 1'b0;
      cap_d[k] = data_out_s;
      if (bit_valid_s) vcnt++;
      if (frame_done_s) begin
        dk = k;
        break;
      end
    end
    chk("t6_done_cycle", dk, SYNC_W + 8 + CRC_LEN);
    chk("t6_valid_bits", vcnt, SYNC_W + 8 + CRC_LEN);
    for (int j = 0; j < 8; j++) sb[7-j] = cap_d[1+j];
    chk("t6_header", sb, 8'hA5);
    for (int b = 0; b < 8; b++) sb[b] = cap_d[SYNC_W + 1 + b];
    chk("t6_payload", sb, 8'h31);
`ifdef RO_FRAME_CRC8_EN
    for (int j = 0; j < 8; j++) sb[7-j] = cap_d[SYNC_W + 9 + j];
    c1 = '0; c1[7:0] = 8'h31;
    chk("t6_crc_model", sb, crc_ref(c1, 8));
    chk("t6_crc_literal", sb, 8'hAD);
`endif
    repeat (8) @(negedge data_clk);
    chk("t6_small_idle", busy_s, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
